// File: rtl/astropix_layers_frame_arbiter_if.sv
// Bus bundle for astropix_layers_frame_arbiter: NUM_LAYERS framed AXIS inputs and one merged
// AXIS output toward the readout FIFO.
// master: the arbiter's view (consumes layer streams, drives the merged stream).
// slave:  the environment's view (layer engines and readout FIFO).
interface astropix_layers_frame_arbiter_if #(
    parameter int unsigned NUM_LAYERS = 3,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEST_WIDTH = 8
);
    logic [NUM_LAYERS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_LAYERS-1:0]            s_axis_tvalid;
    logic [NUM_LAYERS-1:0]            s_axis_tlast;
    logic [NUM_LAYERS-1:0]            s_axis_tready;
    logic [DATA_WIDTH-1:0]            m_axis_tdata;
    logic                             m_axis_tvalid;
    logic                             m_axis_tlast;
    logic [DEST_WIDTH-1:0]            m_axis_tdest;
    logic                             m_axis_tready;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
    );
endinterface

// File: rtl/astropix_layers_frame_arbiter.sv
// Frame-atomic arbiter merging NUM_LAYERS layer byte streams into one readout stream.
// Round-robin or fixed priority with a per-layer enable mask; one output register stage.
// Optional feature: define FRAME_TIMEOUT_EN to abort frames whose source stalls for
// cfg_frame_timeout cycles (a TIMEOUT_BYTE with tlast closes the frame).
module astropix_layers_frame_arbiter #(
    parameter int unsigned           NUM_LAYERS   = 3,
    parameter int unsigned           DATA_WIDTH   = 8,
    parameter int unsigned           DEST_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_BYTE = 8'hFF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    astropix_layers_frame_arbiter_if.master        bus,
    input  logic [NUM_LAYERS-1:0]                  cfg_layer_mask,
    input  logic                                   cfg_priority_fixed,
    input  logic [15:0]                            cfg_frame_timeout,
    input  logic                                   cfg_flush,
    output logic                                   status_busy,
    output logic                                   stat_frame_forwarded,
    output logic                                   stat_timeout
);
    localparam int unsigned GW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    typedef enum logic [0:0] {StIdle, StForward} state_e;

    state_e                state;
    logic [GW-1:0]         grant;
    logic [GW-1:0]         last_grant;
    logic [GW-1:0]         arb_pick;
    logic [NUM_LAYERS-1:0] req;
    logic [NUM_LAYERS-1:0] s_ready;
    logic                  s_valid_g;
    logic                  s_last_g;
    logic [DATA_WIDTH-1:0] s_data_g;
    logic                  m_free;
    logic                  s_accept;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic [DEST_WIDTH-1:0] m_dest;
    logic                  stat_fwd;

    assign req      = bus.s_axis_tvalid & cfg_layer_mask;
    assign m_free   = !m_valid || bus.m_axis_tready;
    assign s_accept = (state == StForward) && s_valid_g && m_free;

    // Pick the next layer: lowest index in fixed mode, else first requester after last_grant.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx      = 0;
        found    = 1'b0;
        arb_pick = '0;
        for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
            if (cfg_priority_fixed) begin
                idx = k;
            end else begin
                idx = 32'(last_grant) + 1 + k;
                if (idx >= NUM_LAYERS) idx = idx - NUM_LAYERS;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                arb_pick = GW'(idx);
            end
        end
    end

    // Select the granted layer's lane and open only its ready while forwarding.
    always_comb begin
        s_valid_g = 1'b0;
        s_last_g  = 1'b0;
        s_data_g  = '0;
        s_ready   = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (grant == GW'(i)) begin
                s_valid_g  = bus.s_axis_tvalid[i];
                s_last_g   = bus.s_axis_tlast[i];
                s_data_g   = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                s_ready[i] = (state == StForward) && m_free;
            end
        end
    end

`ifdef FRAME_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        stat_to;
    logic        timeout_hit;

    // The source has been idle long enough; the grant is reclaimed.
    assign timeout_hit = (cfg_frame_timeout != 16'd0) && (to_cnt == cfg_frame_timeout) &&
                         !s_valid_g;
    assign stat_timeout = stat_to;
`else
    logic unused_timeout;

    assign unused_timeout = ^cfg_frame_timeout;
    assign stat_timeout   = 1'b0;
`endif

    // Arbitration FSM with the registered output stage and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            grant      <= '0;
            last_grant <= GW'(NUM_LAYERS - 1);
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_dest     <= '0;
            stat_fwd   <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            to_cnt     <= '0;
            stat_to    <= 1'b0;
`endif
        end else begin
            stat_fwd <= m_valid && bus.m_axis_tready && m_last;
`ifdef FRAME_TIMEOUT_EN
            stat_to  <= 1'b0;
`endif
            if (cfg_flush) begin
                state   <= StIdle;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
                to_cnt  <= '0;
`endif
            end else begin
                // Output drains unless a new beat overwrites it below.
                if (m_valid && bus.m_axis_tready) m_valid <= 1'b0;
                case (state)
                    StIdle: begin
                        if (|req) begin
                            grant      <= arb_pick;
                            last_grant <= arb_pick;
                            state      <= StForward;
`ifdef FRAME_TIMEOUT_EN
                            to_cnt     <= '0;
`endif
                        end
                    end
                    StForward: begin
                        if (s_accept) begin
                            m_data  <= s_data_g;
                            m_last  <= s_last_g;
                            m_dest  <= DEST_WIDTH'(grant);
                            m_valid <= 1'b1;
`ifdef FRAME_TIMEOUT_EN
                            to_cnt  <= '0;
`endif
                            if (s_last_g) state <= StIdle;
                        end
`ifdef FRAME_TIMEOUT_EN
                        else if (timeout_hit) begin
                            // Wait for a free output slot, then close the frame with filler.
                            if (m_free) begin
                                m_data  <= TIMEOUT_BYTE;
                                m_last  <= 1'b1;
                                m_dest  <= DEST_WIDTH'(grant);
                                m_valid <= 1'b1;
                                stat_to <= 1'b1;
                                to_cnt  <= '0;
                                state   <= StIdle;
                            end
                        end else if (!s_valid_g && (cfg_frame_timeout != 16'd0)) begin
                            to_cnt <= to_cnt + 16'd1;
                        end
`endif
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign bus.s_axis_tready    = s_ready;
    assign bus.m_axis_tdata     = m_data;
    assign bus.m_axis_tvalid    = m_valid;
    assign bus.m_axis_tlast     = m_last;
    assign bus.m_axis_tdest     = m_dest;
    assign status_busy          = (state == StForward);
    assign stat_frame_forwarded = stat_fwd;
endmodule

// File: tb/tb_astropix_layers_frame_arbiter.sv
// Self-checking bench for astropix_layers_frame_arbiter: per-layer byte queues feed the DUT,
// a scoreboard checks every output beat, and a frame-level arbitration model checks grant order.
module tb_astropix_layers_frame_arbiter;
    localparam int NL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NL-1:0] cfg_layer_mask;
    logic          cfg_priority_fixed;
    logic [15:0]   cfg_frame_timeout;
    logic          cfg_flush;
    logic          status_busy;
    logic          stat_frame_forwarded;
    logic          stat_timeout;

    astropix_layers_frame_arbiter_if #(.NUM_LAYERS(NL), .DATA_WIDTH(8), .DEST_WIDTH(8)) bus ();

    astropix_layers_frame_arbiter #(.NUM_LAYERS(NL), .DATA_WIDTH(8), .DEST_WIDTH(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (bus),
        .cfg_layer_mask       (cfg_layer_mask),
        .cfg_priority_fixed   (cfg_priority_fixed),
        .cfg_frame_timeout    (cfg_frame_timeout),
        .cfg_flush            (cfg_flush),
        .status_busy          (status_busy),
        .stat_frame_forwarded (stat_frame_forwarded),
        .stat_timeout         (stat_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] src_d [NL][$];
    bit         src_l [NL][$];
    logic [7:0] exp_d [NL][$];
    bit         exp_l [NL][$];
    bit         vld [NL];
    int         gap_pct = 0;
    int         rdy_mode = 0;
    bit         rdy_tog = 1'b0;
    bit         check_order = 1'b1;
    bit         model_fixed = 1'b0;
    logic [NL-1:0] model_mask = '1;
    int         model_last = NL - 1;
    bit         in_frame = 1'b0;
    int         cur_dest = 0;
    int         frames_out = 0;
    int         fwd_pulses = 0;
    int         to_pulses = 0;
    bit         prev_stall = 1'b0;
    logic [17:0] prev_beat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    function automatic int exp_next();
        for (int k = 0; k < NL; k++) begin
            int j;
            j = model_fixed ? k : (model_last + 1 + k) % NL;
            if (model_mask[j] && exp_d[j].size() > 0) return j;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NL; i++)
            if (src_d[i].size() > 0 || exp_d[i].size() > 0) return 1'b1;
        return bus.m_axis_tvalid;
    endfunction

    task automatic push_byte(input int l, input logic [7:0] d, input bit last,
                             input bit to_src, input bit to_exp);
        if (to_src) begin src_d[l].push_back(d); src_l[l].push_back(last); end
        if (to_exp) begin exp_d[l].push_back(d); exp_l[l].push_back(last); end
    endtask

    task automatic push_frame(input int l, input int len);
        for (int b = 0; b < len; b++) push_byte(l, 8'($urandom_range(255)), b == len - 1, 1, 1);
    endtask

    task automatic drive();
        for (int i = 0; i < NL; i++) begin
            if (src_d[i].size() > 0) begin
                if (!vld[i]) vld[i] = ($urandom_range(99) >= 32'(gap_pct));
                bus.s_axis_tdata[i*8 +: 8] = src_d[i][0];
                bus.s_axis_tlast[i]        = src_l[i][0];
            end else begin
                vld[i]                     = 1'b0;
                bus.s_axis_tdata[i*8 +: 8] = 8'h00;
                bus.s_axis_tlast[i]        = 1'b0;
            end
            bus.s_axis_tvalid[i] = vld[i];
        end
        case (rdy_mode)
            1: begin rdy_tog = ~rdy_tog; bus.m_axis_tready = rdy_tog; end
            2: bus.m_axis_tready = 1'($urandom_range(1));
            default: bus.m_axis_tready = 1'b1;
        endcase
    endtask

    task automatic clear_model();
        for (int i = 0; i < NL; i++) begin
            src_d[i].delete(); src_l[i].delete(); exp_d[i].delete(); exp_l[i].delete();
            vld[i] = 1'b0;
        end
        in_frame   = 1'b0;
        prev_stall = 1'b0;
        drive();
    endtask

    // One clock: sample handshakes mid-cycle, score them, drive next inputs after the edge.
    task automatic tick();
        int d;
        @(negedge clk);
        if (prev_stall) begin
            chk("hold_valid", 32'(bus.m_axis_tvalid), 32'd1);
            chk("hold_beat", 32'({bus.m_axis_tdest, bus.m_axis_tlast, bus.m_axis_tdata, 1'b0}),
                32'(prev_beat));
        end
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            d = int'(bus.m_axis_tdest);
            if (!in_frame) begin
                if (check_order) chk("grant_order", 32'(d), 32'(exp_next()));
                in_frame   = 1'b1;
                cur_dest   = d;
                model_last = d;
            end else begin
                chk("no_interleave", 32'(d), 32'(cur_dest));
            end
            if (d < NL && exp_d[d].size() > 0) begin
                chk("beat_data", 32'(bus.m_axis_tdata), 32'(exp_d[d].pop_front()));
                chk("beat_last", 32'(bus.m_axis_tlast), 32'(exp_l[d].pop_front()));
            end else begin
                chk("stray_beat_dest", 32'(d), 32'hFFFF_FFFF);
            end
            if (bus.m_axis_tlast) begin in_frame = 1'b0; frames_out++; end
        end
        for (int i = 0; i < NL; i++) begin
            if (bus.s_axis_tvalid[i] && bus.s_axis_tready[i] && src_d[i].size() > 0) begin
                void'(src_d[i].pop_front());
                void'(src_l[i].pop_front());
                vld[i] = 1'b0;
            end
        end
        if (stat_frame_forwarded) fwd_pulses++;
        if (stat_timeout) to_pulses++;
        prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
        prev_beat  = {bus.m_axis_tdest, bus.m_axis_tlast, bus.m_axis_tdata, 1'b0};
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input string tag, input int budget);
        int c = 0;
        while (pending() && c < budget) begin tick(); c++; end
        chk(tag, 32'(c < budget), 32'd1);
        tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, 32'(bus.m_axis_tvalid), 32'd0);
        chk({tag, "_tlast"}, 32'(bus.m_axis_tlast), 32'd0);
        chk({tag, "_tdata"}, 32'(bus.m_axis_tdata), 32'd0);
        chk({tag, "_tdest"}, 32'(bus.m_axis_tdest), 32'd0);
        chk({tag, "_sready"}, 32'(bus.s_axis_tready), 32'd0);
        chk({tag, "_busy"}, 32'(status_busy), 32'd0);
        chk({tag, "_fwd"}, 32'(stat_frame_forwarded), 32'd0);
        chk({tag, "_to"}, 32'(stat_timeout), 32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_reset_outputs(tag);
        @(posedge clk);
        #1 rst = 1'b0;
        model_last = NL - 1;
        clear_model();
    endtask

    task automatic wait_frame_start(input string tag);
        int c = 0;
        while (!in_frame && c < 100) begin tick(); c++; end
        chk(tag, 32'(in_frame), 32'd1);
    endtask

    initial begin
        int f0;
        int p0;
        int t0;
        int c;
        rst                = 1'b1;
        cfg_layer_mask     = '1;
        cfg_priority_fixed = 1'b0;
        cfg_frame_timeout  = 16'd0;
        cfg_flush          = 1'b0;
        bus.s_axis_tdata   = '0;
        bus.s_axis_tvalid  = '0;
        bus.s_axis_tlast   = '0;
        bus.m_axis_tready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst = 1'b0;
        clear_model();

        // 1: single 4-byte frame from layer 1
        f0 = frames_out; p0 = fwd_pulses;
        push_byte(1, 8'h05, 0, 1, 1); push_byte(1, 8'h11, 0, 1, 1);
        push_byte(1, 8'h22, 0, 1, 1); push_byte(1, 8'h33, 1, 1, 1);
        drain("t1_drain", 100);
        chk("t1_frames", 32'(frames_out - f0), 32'd1);
        chk("t1_fwd_pulses", 32'(fwd_pulses - p0), 32'd1);

        // 2: round-robin among three always-valid layers, then fixed priority
        pulse_reset("t2_reset");
        for (int r = 0; r < 2; r++) for (int l = 0; l < NL; l++) push_frame(l, 2);
        drain("t2_rr_drain", 200);
        cfg_priority_fixed = 1'b1; model_fixed = 1'b1;
        for (int r = 0; r < 3; r++) push_frame(0, 2);
        push_frame(1, 2); push_frame(2, 2);
        drain("t2_fixed_drain", 200);
        cfg_priority_fixed = 1'b0; model_fixed = 1'b0;

        // 3: toggling FIFO ready across an 8-byte frame
        rdy_mode = 1;
        push_frame(0, 8);
        drain("t3_drain", 200);
        rdy_mode = 0;

        // 4: masked-out layer never granted; unmasking mid-frame takes effect next arbitration
        cfg_layer_mask = 3'b101; model_mask = 3'b101;
        for (int l = 0; l < NL; l++) push_frame(l, 2);
        c = 0;
        while ((exp_d[0].size() > 0 || exp_d[2].size() > 0) && c < 100) begin tick(); c++; end
        repeat (10) tick();
        chk("t4_masked_pending", 32'(exp_d[1].size()), 32'd2);
        push_frame(0, 8);
        wait_frame_start("t4_l0_start");
        cfg_layer_mask = 3'b111; model_mask = 3'b111;
        drain("t4_drain", 200);

        // 5: source stalls mid-frame
        check_order = 1'b0;
`ifdef FRAME_TIMEOUT_EN
        cfg_frame_timeout = 16'd10;
        t0 = to_pulses;
        push_byte(2, 8'h41, 0, 1, 1); push_byte(2, 8'h42, 0, 1, 1);
        push_byte(2, 8'hFF, 1, 0, 1);
        c = 0;
        while (exp_d[2].size() > 0 && c < 100) begin tick(); c++; end
        repeat (3) tick();
        chk("t5_filler_seen", 32'(c < 100), 32'd1);
        chk("t5_to_pulses", 32'(to_pulses - t0), 32'd1);
        chk("t5_idle", 32'(status_busy), 32'd0);
        push_byte(2, 8'h43, 0, 1, 1); push_byte(2, 8'h44, 0, 1, 1); push_byte(2, 8'h45, 1, 1, 1);
        drain("t5_drain", 100);
        cfg_frame_timeout = 16'd0;
`else
        cfg_frame_timeout = 16'd10;
        t0 = to_pulses;
        push_byte(2, 8'h41, 0, 1, 1); push_byte(2, 8'h42, 0, 1, 1);
        wait_frame_start("t5_l2_start");
        push_frame(0, 2);
        repeat (40) tick();
        chk("t5_no_timeout", 32'(to_pulses - t0), 32'd0);
        chk("t5_grant_held", 32'(status_busy), 32'd1);
        chk("t5_l0_blocked", 32'(exp_d[0].size()), 32'd2);
        push_byte(2, 8'h43, 0, 1, 1); push_byte(2, 8'h44, 0, 1, 1); push_byte(2, 8'h45, 1, 1, 1);
        drain("t5_drain", 100);
        cfg_frame_timeout = 16'd0;
`endif
        check_order = 1'b1;

        // 6: async reset mid-frame, then flush mid-frame (last_grant must survive flush)
        push_frame(2, 6);
        wait_frame_start("t6_l2_start");
        pulse_reset("t6_rst");
        push_frame(1, 4);
        drain("t6_after_rst", 100);
        push_frame(0, 6);
        wait_frame_start("t6_l0_start");
        cfg_flush = 1'b1;
        tick();
        cfg_flush = 1'b0;
        chk("t6_flush_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("t6_flush_busy", 32'(status_busy), 32'd0);
        chk("t6_flush_sready", 32'(bus.s_axis_tready), 32'd0);
        clear_model();
        push_frame(0, 2); push_frame(2, 2);
        drain("t6_after_flush", 100);

        // Random traffic: gaps, random FIFO ready, frame lengths 1..6
        check_order = 1'b0; gap_pct = 30; rdy_mode = 2;
        f0 = frames_out; p0 = fwd_pulses;
        for (int n = 0; n < 12; n++) push_frame(int'($urandom_range(NL - 1)), int'($urandom_range(6, 1)));
        drain("rand_drain", 3000);
        chk("rand_frames", 32'(frames_out - f0), 32'd12);
        chk("rand_fwd_pulses", 32'(fwd_pulses - p0), 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
